exception_handler_ctrl: RTL and testbench
=========================================

// Module: exception_handler_ctrl
// PURPOSE
//  Parametrised trap/CSR sequencing controller for the exception unit.
//  - Arbitrates NUM_CAUSES trap sources by fixed priority and captures cause and EPC.
//  - Waits for the faulting instruction to retire, bounded by a timeout.
//  - Drives a multi-cycle pipeline flush, then holds until MRET.
//  - Also sequences the two-step CSR read/modify access.
// PARAMETERS
//  NUM_CAUSES      8   trap request lines (>=2); index 0 = highest priority
//  XLEN            64  width of PC/EPC
//  FLUSH_CYCLES    2   cycles flush_o held high per trap (>=1)
//  RETIRE_TIMEOUT  16  max cycles in WAIT_FOR_RETIRE before forced entry (>=1)
// PORTS
//  clock_i               in   1                   clock, all logic on rising edge
//  reset_ni              in   1                   reset, asynchronous, active-low
//  csr_access_request_i  in   1                   request CSR read-modify sequence
//  csr_done_o            out  1                   1-cycle pulse: CSR modify step
//  trap_request_i        in   NUM_CAUSES          per-cause trap request, level
//  trap_pc_i             in   XLEN                PC of trapping instruction
//  retire_i              in   1                   trapping instruction retired
//  mret_i                in   1                   trap handler return
//  flush_o               out  1                   pipeline flush
//  trap_cause_o          out  $clog2(NUM_CAUSES)  captured cause index
//  epc_o                 out  XLEN                captured exception PC
//  retire_timeout_o      out  1                   1-cycle pulse: retire wait expired
//  busy_o                out  1                   state != IDLE
// BEHAVIOUR
//  Reset (reset_ni=0, async):
//  - state=RESET; flush_o, csr_done_o, retire_timeout_o, trap_cause_o, epc_o, counters all 0.
//  - busy_o=1 while in RESET.
//  States: RESET, IDLE, CSR_READ, CSR_MODIFY, WAIT_FOR_RETIRE, PROCESS_TRAP, WAIT_FOR_RETURN.
//  - RESET -> IDLE unconditionally, on the first edge after reset release.
//  - IDLE, csr_access_request_i=1 -> CSR_READ.
//    CSR has priority over a simultaneous trap; the trap is not captured.
//  - IDLE, |trap_request_i and no CSR request -> WAIT_FOR_RETIRE.
//    On the same edge: trap_cause_o <= index of lowest set bit; epc_o <= trap_pc_i.
//  - CSR_READ -> CSR_MODIFY -> IDLE; csr_done_o=1 exactly during CSR_MODIFY.
//  - WAIT_FOR_RETIRE: wait counter increments each cycle from 0 (cleared on entry).
//    - retire_i=1 -> PROCESS_TRAP.
//    - Counter reaches RETIRE_TIMEOUT-1 with retire_i=0 -> PROCESS_TRAP;
//      retire_timeout_o=1 for that one cycle.
//    - retire_i=1 on the final cycle: retire wins, no timeout pulse.
//  - PROCESS_TRAP: flush_o=1 for exactly FLUSH_CYCLES cycles (flush counter),
//    then -> WAIT_FOR_RETURN. flush_o is registered-state decoded: high only in PROCESS_TRAP.
//  - WAIT_FOR_RETURN: mret_i=1 -> IDLE; otherwise stay.
//  - trap_cause_o/epc_o hold their value until the next trap capture; they are not cleared by mret.
//  - trap_request_i and csr_access_request_i outside IDLE are ignored, not latched;
//    requesters hold their lines.
//  - mret_i outside WAIT_FOR_RETURN is ignored. retire_i outside WAIT_FOR_RETIRE is ignored.
//  - Reset mid-operation: immediate return to reset values; no flush completes.
//  - Counters sized $clog2(max(FLUSH_CYCLES,RETIRE_TIMEOUT)+1); no wrap possible.
//  - All state-decoded case statements are fully specified; unreachable encodings -> IDLE.
// TESTING
//  1. Reset released, no inputs -> RESET 1 cycle, then IDLE; busy_o=0; all outputs 0.
//  2. csr_access_request_i 1 cycle, trap_request_i=8'h04 same cycle -> CSR_READ, CSR_MODIFY;
//     csr_done_o 1 cycle; back to IDLE; trap_cause_o stays 0.
//  3. trap_request_i=8'h28, trap_pc_i=64'h8000_1000; retire_i after 3 cycles
//     -> trap_cause_o=3, epc_o=64'h8000_1000; flush_o high exactly 2 cycles.
//  4. Trap with retire_i held 0 -> retire_timeout_o pulses once, 16 cycles after entry;
//     flush follows. Repeat with retire_i on cycle 16 -> no pulse.
//  5. In WAIT_FOR_RETURN, apply trap_request_i=8'h01 -> ignored.
//     Then mret_i=1 -> IDLE; the held trap is then captured with cause=0.
//  6. reset_ni low during PROCESS_TRAP -> flush_o=0 immediately;
//     after release, trap_cause_o=0 and epc_o=0.

Source files
------------

// File: rtl/exception_handler_ctrl_if.sv
// Trap/CSR sequencing bus between the exception unit controller and its requesters.
// The slave modport is the controller's view; master is the requester/pipeline view.
interface exception_handler_ctrl_if #(
    parameter int unsigned NUM_CAUSES = 8,
    parameter int unsigned XLEN       = 64
);
    localparam int unsigned CAUSE_W = $clog2(NUM_CAUSES);

    logic                  csr_access_request_i;
    logic                  csr_done_o;
    logic [NUM_CAUSES-1:0] trap_request_i;
    logic [XLEN-1:0]       trap_pc_i;
    logic                  retire_i;
    logic                  mret_i;
    logic                  flush_o;
    logic [CAUSE_W-1:0]    trap_cause_o;
    logic [XLEN-1:0]       epc_o;
    logic                  retire_timeout_o;
    logic                  busy_o;

    modport slave (
        input  csr_access_request_i,
        input  trap_request_i,
        input  trap_pc_i,
        input  retire_i,
        input  mret_i,
        output csr_done_o,
        output flush_o,
        output trap_cause_o,
        output epc_o,
        output retire_timeout_o,
        output busy_o
    );

    modport master (
        output csr_access_request_i,
        output trap_request_i,
        output trap_pc_i,
        output retire_i,
        output mret_i,
        input  csr_done_o,
        input  flush_o,
        input  trap_cause_o,
        input  epc_o,
        input  retire_timeout_o,
        input  busy_o
    );
endinterface

// File: rtl/exception_handler_ctrl.sv
// Trap/CSR sequencing controller: fixed-priority trap capture, bounded retire wait,
// multi-cycle pipeline flush, MRET return, and the two-step CSR read/modify access.
module exception_handler_ctrl #(
    parameter int unsigned NUM_CAUSES     = 8,
    parameter int unsigned XLEN           = 64,
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter int unsigned RETIRE_TIMEOUT = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    exception_handler_ctrl_if.slave  bus
);

    localparam int unsigned CAUSE_W = $clog2(NUM_CAUSES);
    localparam int unsigned CNT_MAX = (FLUSH_CYCLES > RETIRE_TIMEOUT) ? FLUSH_CYCLES
                                                                       : RETIRE_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RETIRE_LAST = CNT_W'(RETIRE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RESET           = 3'd0,
        ST_IDLE            = 3'd1,
        ST_CSR_READ        = 3'd2,
        ST_CSR_MODIFY      = 3'd3,
        ST_WAIT_FOR_RETIRE = 3'd4,
        ST_PROCESS_TRAP    = 3'd5,
        ST_WAIT_FOR_RETURN = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]      epc_q, epc_d;
    logic                 flush_q, flush_d;
    logic                 csr_done_q, csr_done_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q, busy_d;

    logic                 trap_any_c;
    logic [CAUSE_W-1:0]   trap_idx_c;

    // Fixed-priority encoder: lowest set request bit wins.
    always_comb begin
        trap_any_c = |bus.trap_request_i;
        trap_idx_c = '0;
        for (int i = int'(NUM_CAUSES) - 1; i >= 0; i--) begin
            if (bus.trap_request_i[i]) begin
                trap_idx_c = CAUSE_W'(i);
            end
        end
    end

    // Next-state, counter, capture and registered-output decode.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        timeout_d   = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.csr_access_request_i) begin
                    state_d = ST_CSR_READ;
                end else if (trap_any_c) begin
                    state_d    = ST_WAIT_FOR_RETIRE;
                    wait_cnt_d = '0;
                    cause_d    = trap_idx_c;
                    epc_d      = bus.trap_pc_i;
                end
            end
            ST_CSR_READ: begin
                state_d = ST_CSR_MODIFY;
            end
            ST_CSR_MODIFY: begin
                state_d = ST_IDLE;
            end
            ST_WAIT_FOR_RETIRE: begin
                // Retire on the final count still wins over the timeout.
                if (bus.retire_i) begin
                    state_d     = ST_PROCESS_TRAP;
                    flush_cnt_d = '0;
                end else if (wait_cnt_q == RETIRE_LAST) begin
                    state_d     = ST_PROCESS_TRAP;
                    flush_cnt_d = '0;
                    timeout_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_PROCESS_TRAP: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_WAIT_FOR_RETURN;
                end else begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_FOR_RETURN: begin
                if (bus.mret_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        flush_d    = (state_d == ST_PROCESS_TRAP);
        csr_done_d = (state_d == ST_CSR_MODIFY);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_RESET;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
            cause_q     <= '0;
            epc_q       <= '0;
            flush_q     <= 1'b0;
            csr_done_q  <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            flush_q     <= flush_d;
            csr_done_q  <= csr_done_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.flush_o          = flush_q;
    assign bus.csr_done_o       = csr_done_q;
    assign bus.retire_timeout_o = timeout_q;
    assign bus.busy_o           = busy_q;
    assign bus.trap_cause_o     = cause_q;
    assign bus.epc_o            = epc_q;

endmodule

// File: tb/tb_exception_handler_ctrl.sv
// Bench for exception_handler_ctrl: table of transactions checked by a scoreboard
// fed from a negedge monitor, plus hand sequences for ignore and mid-flush reset.
module tb_exception_handler_ctrl;

    localparam int unsigned NC      = 8;
    localparam int unsigned XL      = 64;
    localparam int unsigned FLUSH   = 2;
    localparam int unsigned TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exception_handler_ctrl_if #(.NUM_CAUSES(NC), .XLEN(XL)) bus();

    exception_handler_ctrl #(
        .NUM_CAUSES    (NC),
        .XLEN          (XL),
        .FLUSH_CYCLES  (FLUSH),
        .RETIRE_TIMEOUT(TIMEOUT)
    ) dut (
        .clock_i (clk),
        .reset_ni(rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        bit          csr;
        logic [7:0]  trap;
        logic [63:0] pc;
        int          dly;       // cycles after entry before retire; -1 = never
        logic [2:0]  cause;
        logic [63:0] epc;
        bit          to;
        int          fs;        // monitor cycle index of first flush sample
    } vec_t;

    typedef struct {
        logic [2:0]  cause;
        logic [63:0] epc;
        int          done_cnt;
        int          done_idx;
        int          to_cnt;
        int          to_idx;
        int          fs;
        int          fl;
    } exp_t;

    vec_t vecs [7];
    exp_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push_exp(vec_t v);
        exp_t e;
        e.cause = v.cause;
        e.epc   = v.epc;
        if (v.csr) begin
            e.done_cnt = 1; e.done_idx = 1;
            e.to_cnt   = 0; e.to_idx   = -1;
            e.fs       = -1; e.fl      = 0;
        end else begin
            e.done_cnt = 0; e.done_idx = -1;
            e.to_cnt   = v.to ? 1 : 0;
            e.to_idx   = v.to ? int'(TIMEOUT) : -1;
            e.fs       = v.fs;
            e.fl       = int'(FLUSH);
        end
        exp_q.push_back(e);
    endfunction

    // Monitor: one record per busy period, compared against the scoreboard head.
    bit          active = 1'b0;
    int          k, done_cnt, done_idx, to_cnt, to_idx, fs, fl, txn = 0;
    logic [2:0]  m_cause;
    logic [63:0] m_epc;
    exp_t        m_exp;

    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            active = 1'b0;
        end else if (bus.busy_o) begin
            if (!active) begin
                active = 1'b1; k = 0;
                done_cnt = 0; done_idx = -1; to_cnt = 0; to_idx = -1; fs = -1; fl = 0;
                m_cause = bus.trap_cause_o; m_epc = bus.epc_o;
            end
            if (bus.csr_done_o) begin done_cnt++; done_idx = k; end
            if (bus.retire_timeout_o) begin to_cnt++; to_idx = k; end
            if (bus.flush_o) begin if (fs < 0) fs = k; fl++; end
            k++;
        end else if (active) begin
            active = 1'b0;
            if (exp_q.size() == 0) begin
                chk($sformatf("txn%0d_unexpected", txn), 64'd1, 64'd0);
            end else begin
                m_exp = exp_q.pop_front();
                chk($sformatf("txn%0d_cause", txn), 64'(m_cause), 64'(m_exp.cause));
                chk($sformatf("txn%0d_epc", txn), m_epc, m_exp.epc);
                chk($sformatf("txn%0d_csr_done_cnt", txn), 64'(done_cnt), 64'(m_exp.done_cnt));
                chk($sformatf("txn%0d_csr_done_idx", txn), 64'(done_idx), 64'(m_exp.done_idx));
                chk($sformatf("txn%0d_timeout_cnt", txn), 64'(to_cnt), 64'(m_exp.to_cnt));
                chk($sformatf("txn%0d_timeout_idx", txn), 64'(to_idx), 64'(m_exp.to_idx));
                chk($sformatf("txn%0d_flush_start", txn), 64'(fs), 64'(m_exp.fs));
                chk($sformatf("txn%0d_flush_len", txn), 64'(fl), 64'(m_exp.fl));
            end
            txn++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy_o && n < 50) begin tick(); n++; end
        if (n >= 50) chk("wait_idle_bound", 64'd1, 64'd0);
    endtask

    task automatic wait_flush_done();
        int n = 0;
        bit seen = 1'b0;
        while (n < 40) begin
            if (bus.flush_o) seen = 1'b1;
            else if (seen) break;
            tick();
            n++;
        end
        if (n >= 40) chk("flush_wait_bound", 64'd1, 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input bit hold_return);
        wait_idle();
        push_exp(v);
        bus.csr_access_request_i = v.csr;
        bus.trap_request_i       = v.trap;
        bus.trap_pc_i            = v.pc;
        tick();
        bus.csr_access_request_i = 1'b0;
        bus.trap_request_i       = '0;
        if (!v.csr) begin
            if (v.dly >= 0) begin
                bus.mret_i = 1'b1;              // must be ignored while waiting to retire
                repeat (v.dly) tick();
                bus.mret_i   = 1'b0;
                bus.retire_i = 1'b1;
                tick();
                bus.retire_i = 1'b0;
            end
            wait_flush_done();
            if (!hold_return) begin
                bus.mret_i = 1'b1;
                tick();
                bus.mret_i = 1'b0;
            end
        end
    endtask

    vec_t ret_trap;

    initial begin
        bus.csr_access_request_i = 1'b0;
        bus.trap_request_i       = '0;
        bus.trap_pc_i            = '0;
        bus.retire_i             = 1'b0;
        bus.mret_i               = 1'b0;

        //            csr   trap    pc                dly cause epc               to    fs
        vecs[0] = '{1'b1, 8'h04, 64'h10,          0,  3'd0, 64'h0,          1'b0, -1};
        vecs[1] = '{1'b0, 8'h28, 64'h8000_1000,   3,  3'd3, 64'h8000_1000,  1'b0,  4};
        vecs[2] = '{1'b0, 8'h80, 64'hA0,         -1,  3'd7, 64'hA0,         1'b1, 16};
        vecs[3] = '{1'b0, 8'h06, 64'hB0,         15,  3'd1, 64'hB0,         1'b0, 16};
        vecs[4] = '{1'b1, 8'h00, 64'h0,           0,  3'd1, 64'hB0,         1'b0, -1};
        vecs[5] = '{1'b0, 8'h40, 64'h200,         1,  3'd6, 64'h200,        1'b0,  2};
        vecs[6] = '{1'b0, 8'hFF, 64'h4,           0,  3'd0, 64'h4,          1'b0,  1};
        ret_trap = '{1'b0, 8'h01, 64'hDEAD_0000,  2,  3'd0, 64'hDEAD_0000,  1'b0,  3};

        // Reset values, RESET state for one cycle, then IDLE.
        #12;
        chk("rst_flush", 64'(bus.flush_o), 64'd0);
        chk("rst_csr_done", 64'(bus.csr_done_o), 64'd0);
        chk("rst_timeout", 64'(bus.retire_timeout_o), 64'd0);
        chk("rst_cause", 64'(bus.trap_cause_o), 64'd0);
        chk("rst_epc", bus.epc_o, 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("reset_state_busy", 64'(bus.busy_o), 64'd1);
        tick();
        chk("idle_busy", 64'(bus.busy_o), 64'd0);
        chk("idle_flush", 64'(bus.flush_o), 64'd0);
        chk("idle_csr_done", 64'(bus.csr_done_o), 64'd0);
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

        // Requests while waiting for MRET are ignored; the held trap is taken after return.
        run_vec(vecs[5], 1'b1);
        bus.trap_request_i       = 8'h01;
        bus.trap_pc_i            = 64'hDEAD_0000;
        bus.csr_access_request_i = 1'b1;
        bus.retire_i             = 1'b1;
        repeat (3) tick();
        chk("ret_hold_busy", 64'(bus.busy_o), 64'd1);
        chk("ret_hold_cause", 64'(bus.trap_cause_o), 64'd6);
        chk("ret_hold_epc", bus.epc_o, 64'h200);
        chk("ret_hold_flush", 64'(bus.flush_o), 64'd0);
        bus.csr_access_request_i = 1'b0;
        bus.retire_i             = 1'b0;
        push_exp(ret_trap);
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        tick();
        bus.trap_request_i = '0;
        repeat (ret_trap.dly) tick();
        bus.retire_i = 1'b1;
        tick();
        bus.retire_i = 1'b0;
        wait_flush_done();
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;

        // Reset asserted mid-flush.
        tick();
        mon_en = 1'b0;
        bus.trap_request_i = 8'h10;
        bus.trap_pc_i      = 64'h1234;
        tick();
        bus.trap_request_i = '0;
        bus.retire_i       = 1'b1;
        tick();
        bus.retire_i = 1'b0;
        chk("pre_reset_flush", 64'(bus.flush_o), 64'd1);
        chk("pre_reset_cause", 64'(bus.trap_cause_o), 64'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_flush", 64'(bus.flush_o), 64'd0);
        chk("mid_reset_busy", 64'(bus.busy_o), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("post_reset_busy", 64'(bus.busy_o), 64'd0);
        chk("post_reset_flush", 64'(bus.flush_o), 64'd0);
        chk("post_reset_cause", 64'(bus.trap_cause_o), 64'd0);
        chk("post_reset_epc", bus.epc_o, 64'd0);
        mon_en = 1'b1;

        run_vec(vecs[6], 1'b0);

        repeat (3) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
